// File: rtl/alu_seq32_if.sv
// Bundle between a requester, the sequential ALU controller and the external 8-bit ALU.
// The master side is the requester plus the ALU; the slave side is alu_seq32.
interface alu_seq32_if #(
  parameter int NBYTES = 4
);
  localparam int W = 8 * NBYTES;

  logic         start;
  logic [2:0]   op;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         cin;
  logic [W-1:0] result;
  logic         cout;
  logic         busy;
  logic         done;

  logic [2:0]   alu_oper;
  logic [7:0]   alu_a;
  logic [7:0]   alu_b;
  logic         alu_cin;
  logic [7:0]   alu_sum;
  logic         alu_cout;

  modport master (
    output start, op, x, y, cin, alu_sum, alu_cout,
    input  result, cout, busy, done, alu_oper, alu_a, alu_b, alu_cin
  );

  modport slave (
    input  start, op, x, y, cin, alu_sum, alu_cout,
    output result, cout, busy, done, alu_oper, alu_a, alu_b, alu_cin
  );
endinterface

// File: rtl/alu_seq32.sv
// Runs an NBYTES-wide ALU operation through an external 8-bit ALU, one byte slice
// per cycle, chaining the carry between slices.
module alu_seq32 #(
  parameter int NBYTES = 4
) (
  input  logic       clk,
  input  logic       rst,
  alu_seq32_if.slave bus
);
  localparam int            IW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          idx_q;
  logic [2:0]             op_q;
  logic [NBYTES-1:0][7:0] x_q, y_q, acc_q, acc_d;
  logic                   cin_q;
  logic                   carry_q;
  logic                   arith;

  // Only add / subtract / reverse-subtract produce a meaningful carry.
  assign arith = (op_q <= 3'b010);

  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    acc_d[idx_q]   = bus.alu_sum;
    bus.busy       = 1'b0;
    bus.done       = 1'b0;
    bus.alu_oper   = '0;
    bus.alu_a      = '0;
    bus.alu_b      = '0;
    bus.alu_cin    = 1'b0;
    case (state_q)
      IDLE: if (bus.start) state_d = RUN;
      RUN: begin
        bus.busy     = 1'b1;
        bus.alu_oper = op_q;
        bus.alu_a    = x_q[idx_q];
        bus.alu_b    = y_q[idx_q];
        if (idx_q == '0) begin
          bus.alu_cin = cin_q;
        end else begin
          // The ALU inverts cin for op 010, so feed it the inverted chain carry.
          case (op_q)
            3'b000, 3'b001: bus.alu_cin = carry_q;
            3'b010:         bus.alu_cin = ~carry_q;
            default:        bus.alu_cin = 1'b0;
          endcase
        end
        if (idx_q == LAST) state_d = DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      op_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      cin_q      <= 1'b0;
      carry_q    <= 1'b0;
      // NOTE: the accumulator is a handful of flops, not a RAM, so it is reset
      // with everything else and an aborted operation leaves no trace.
      acc_q      <= '0;
      bus.result <= '0;
      bus.cout   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            op_q  <= bus.op;
            x_q   <= bus.x;
            y_q   <= bus.y;
            cin_q <= bus.cin;
            idx_q <= '0;
          end
        end
        RUN: begin
          acc_q   <= acc_d;
          carry_q <= bus.alu_cout;
          if (idx_q == LAST) begin
            idx_q      <= '0;
            bus.result <= acc_d;
            bus.cout   <= arith & bus.alu_cout;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
